// File: rtl/hazard_fwd_unit_if.sv
// Decode-side bus of the hazard/forwarding unit: the ID instruction fields
// and flush go in, stall, operand selects and perf counters come out.
interface hazard_fwd_unit_if #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int CNT_W      = 32
);

  localparam int SW = $clog2(FWD_STAGES + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              flush;

  logic              stall;
  logic [SW-1:0]     fwd_sel1;
  logic [SW-1:0]     fwd_sel2;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  fwd_count;

  // Decoder side: presents the instruction in ID and consumes the steering.
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_memread, flush,
    input  stall, fwd_sel1, fwd_sel2, stall_count, fwd_count
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_memread, flush,
    output stall, fwd_sel1, fwd_sel2, stall_count, fwd_count
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the in-order pipeline.
// A short scoreboard follows every instruction leaving ID through the
// post-decode stages; the youngest in-flight writer of a source register
// decides where that operand comes from, and a load that has not yet
// produced its data holds ID for a cycle.
module hazard_fwd_unit #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_fwd_unit_if.slave  bus
);

  localparam int SW = $clog2(FWD_STAGES + 1);

  // One scoreboard slot: valid, destination, writes-rd, is-a-load.
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } entry_t;

  // Index k is the stage number: 1 = EX, 2 = MEM, ...
  entry_t           r_sb [1:FWD_STAGES];
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_fwdCnt;

  logic [SW-1:0]    w_pick1;
  logic [SW-1:0]    w_pick2;
  logic             w_haz1;
  logic             w_haz2;
  logic             w_stall;
  logic [SW-1:0]    w_sel1;
  logic [SW-1:0]    w_sel2;
  logic             w_anyFwd;
  entry_t           w_newEntry;

  // An entry supplies an operand only if it really writes that register,
  // the register is not x0, and the ID instruction really reads it.
  function automatic logic entryMatches(input entry_t e,
                                        input logic [REG_AW-1:0] rs,
                                        input logic used,
                                        input logic idValid);
    return e.v && e.wr && (e.rd == rs) && (rs != '0) && used && idValid;
  endfunction

  // Scan oldest to youngest so the youngest matching producer is the one
  // left standing; remember whether it is a load still short of its data.
  always_comb begin
    w_pick1 = '0;
    w_pick2 = '0;
    w_haz1  = 1'b0;
    w_haz2  = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (entryMatches(r_sb[k], bus.id_rs1, bus.id_rs1_used, bus.id_valid)) begin
        w_pick1 = SW'(k);
        w_haz1  = r_sb[k].ld && (k <= LOAD_LAT);
      end
      if (entryMatches(r_sb[k], bus.id_rs2, bus.id_rs2_used, bus.id_valid)) begin
        w_pick2 = SW'(k);
        w_haz2  = r_sb[k].ld && (k <= LOAD_LAT);
      end
    end
  end

  // A load-use operand reads the register file while ID waits; a flush
  // kills the ID instruction so there is nothing left to hold.
  always_comb begin
    w_sel1   = w_haz1 ? '0 : w_pick1;
    w_sel2   = w_haz2 ? '0 : w_pick2;
    w_stall  = (w_haz1 || w_haz2) && !bus.flush;
    w_anyFwd = (w_sel1 != '0) || (w_sel2 != '0);
  end

  // What enters EX next: a bubble whenever ID is held or killed.
  always_comb begin
    w_newEntry    = '0;
    w_newEntry.v  = bus.id_valid && !w_stall && !bus.flush;
    w_newEntry.rd = bus.id_rd;
    w_newEntry.wr = bus.id_regwrite;
    w_newEntry.ld = bus.id_memread;
  end

  // Advance the scoreboard one stage per cycle; the oldest slot falls off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        r_sb[k] <= '0;
      end
    end else begin
      for (int k = FWD_STAGES; k >= 2; k--) begin
        r_sb[k] <= r_sb[k-1];
      end
      r_sb[1] <= w_newEntry;
    end
  end

  // Saturating event counters for performance debug.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stallCnt <= '0;
      r_fwdCnt   <= '0;
    end else begin
      if (w_stall && (r_stallCnt != {CNT_W{1'b1}})) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
      if (w_anyFwd && (r_fwdCnt != {CNT_W{1'b1}})) begin
        r_fwdCnt <= r_fwdCnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall       = w_stall;
  assign bus.fwd_sel1    = w_sel1;
  assign bus.fwd_sel2    = w_sel2;
  assign bus.stall_count = r_stallCnt;
  assign bus.fwd_count   = r_fwdCnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: a cycle-by-cycle instruction table with
// hand-computed steering, then reset-during-stall and counter saturation.
module tb_hazard_fwd_unit;

  logic clk;
  logic rst;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
    int         expStall;
    int         expSel1;
    int         expSel2;
  } vec_t;

  vec_t vecs[$];

  hazard_fwd_unit_if #(.REG_AW(5), .FWD_STAGES(2), .CNT_W(32)) hif ();
  hazard_fwd_unit_if #(.REG_AW(5), .FWD_STAGES(2), .CNT_W(3))  hif3 ();

  hazard_fwd_unit #(.REG_AW(5), .FWD_STAGES(2), .LOAD_LAT(1), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  hazard_fwd_unit #(.REG_AW(5), .FWD_STAGES(2), .LOAD_LAT(1), .CNT_W(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (hif3)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic addVec(input string name, input logic v,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic fl,
                        input int eStall, input int eSel1, input int eSel2);
    vec_t t;
    t.name = name; t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
    t.rd = rd; t.rw = rw; t.mr = mr; t.fl = fl;
    t.expStall = eStall; t.expSel1 = eSel1; t.expSel2 = eSel2;
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input vec_t t);
    hif.id_valid    = t.v;
    hif.id_rs1      = t.rs1;
    hif.id_rs2      = t.rs2;
    hif.id_rs1_used = t.u1;
    hif.id_rs2_used = t.u2;
    hif.id_rd       = t.rd;
    hif.id_regwrite = t.rw;
    hif.id_memread  = t.mr;
    hif.flush       = t.fl;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive3(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr);
    hif3.id_valid    = v;
    hif3.id_rs1      = rs1;
    hif3.id_rs2      = rs2;
    hif3.id_rs1_used = u1;
    hif3.id_rs2_used = u2;
    hif3.id_rd       = rd;
    hif3.id_regwrite = rw;
    hif3.id_memread  = mr;
    hif3.flush       = 1'b0;
  endtask

  initial begin
    vec_t idle;
    int   expStallCnt;
    int   expFwdCnt;
    checks      = 0;
    errors      = 0;
    expStallCnt = 0;
    expFwdCnt   = 0;

    //      name            v  rs1 rs2 u1 u2 rd rw mr fl  stall s1 s2
    addVec("add_x5",        1, 1,  2,  1, 1, 5, 1, 0, 0,  0,   0, 0);
    addVec("add_x6_x5",     1, 5,  1,  1, 1, 6, 1, 0, 0,  0,   1, 0);
    addVec("nop_a",         0, 0,  0,  0, 0, 0, 0, 0, 0,  0,   0, 0);
    addVec("sub_x7_x2_x6",  1, 2,  6,  1, 1, 7, 1, 0, 0,  0,   0, 2);
    addVec("nop_b",         0, 0,  0,  0, 0, 0, 0, 0, 0,  0,   0, 0);
    addVec("lw_x5",         1, 1,  0,  1, 0, 5, 1, 1, 0,  0,   0, 0);
    addVec("use_stall",     1, 5,  5,  1, 1, 6, 1, 0, 0,  1,   0, 0);
    addVec("use_resolved",  1, 5,  5,  1, 1, 6, 1, 0, 0,  0,   2, 2);
    addVec("addi_x0",       1, 0,  0,  1, 0, 0, 1, 0, 0,  0,   0, 0);
    addVec("add_x1_x0_x0",  1, 0,  0,  1, 1, 1, 1, 0, 0,  0,   0, 0);
    addVec("rs1_unused",    1, 1,  3,  0, 1, 8, 1, 0, 0,  0,   0, 0);
    addVec("add_x7_old",    1, 0,  0,  1, 0, 7, 1, 0, 0,  0,   0, 0);
    addVec("or_x7_young",   1, 2,  3,  1, 1, 7, 1, 0, 0,  0,   0, 0);
    addVec("read_x7",       1, 7,  7,  1, 1, 9, 1, 0, 0,  0,   1, 1);
    addVec("lw_x5_b",       1, 2,  0,  1, 0, 5, 1, 1, 0,  0,   0, 0);
    addVec("flush_hazard",  1, 5,  0,  1, 1, 6, 1, 0, 1,  0,   0, 0);
    addVec("after_flush",   1, 5,  6,  1, 1, 10, 1, 0, 0, 0,   2, 0);

    idle = '{name: "idle", v: 1'b0, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0,
             rd: 5'd0, rw: 1'b0, mr: 1'b0, fl: 1'b0,
             expStall: 0, expSel1: 0, expSel2: 0};

    rst = 1'b0;
    applyStimulus(idle);
    drive3(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_stall",    int'(hif.stall), 0);
    checkOutput("reset_sel1",     int'(hif.fwd_sel1), 0);
    checkOutput("reset_sel2",     int'(hif.fwd_sel2), 0);
    checkOutput("reset_stallcnt", int'(hif.stall_count), 0);
    checkOutput("reset_fwdcnt",   int'(hif.fwd_count), 0);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput({vecs[i].name, "_stall"},    int'(hif.stall),       vecs[i].expStall);
      checkOutput({vecs[i].name, "_sel1"},     int'(hif.fwd_sel1),    vecs[i].expSel1);
      checkOutput({vecs[i].name, "_sel2"},     int'(hif.fwd_sel2),    vecs[i].expSel2);
      checkOutput({vecs[i].name, "_stallcnt"}, int'(hif.stall_count), expStallCnt);
      checkOutput({vecs[i].name, "_fwdcnt"},   int'(hif.fwd_count),   expFwdCnt);
      if (vecs[i].expStall != 0) expStallCnt++;
      if (vecs[i].expSel1 != 0 || vecs[i].expSel2 != 0) expFwdCnt++;
      @(posedge clk);
      #1;
    end
    applyStimulus(idle);
    @(negedge clk);
    checkOutput("table_stallcnt", int'(hif.stall_count), 1);
    checkOutput("table_fwdcnt",   int'(hif.fwd_count), 5);

    // Reset dropped in the middle of a load-use stall.
    @(posedge clk);
    #1;
    applyStimulus('{name: "lw", v: 1'b1, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0,
                    rd: 5'd5, rw: 1'b1, mr: 1'b1, fl: 1'b0,
                    expStall: 0, expSel1: 0, expSel2: 0});
    @(posedge clk);
    #1;
    applyStimulus('{name: "use", v: 1'b1, rs1: 5'd5, rs2: 5'd5, u1: 1'b1, u2: 1'b1,
                    rd: 5'd6, rw: 1'b1, mr: 1'b0, fl: 1'b0,
                    expStall: 0, expSel1: 0, expSel2: 0});
    @(negedge clk);
    checkOutput("pre_reset_stall", int'(hif.stall), 1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midreset_stall",    int'(hif.stall), 0);
    checkOutput("midreset_sel1",     int'(hif.fwd_sel1), 0);
    checkOutput("midreset_stallcnt", int'(hif.stall_count), 0);
    checkOutput("midreset_fwdcnt",   int'(hif.fwd_count), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("post_reset_stall", int'(hif.stall), 0);
    applyStimulus(idle);

    // Narrow counter: nine load-use stalls must pin at 7.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      drive3(1, 0, 0, 0, 0, 5, 1, 1);
      @(posedge clk);
      #1;
      drive3(1, 5, 0, 1, 0, 6, 1, 0);
      @(negedge clk);
      checkOutput("sat_stall", int'(hif3.stall), 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("sat_stallcnt", int'(hif3.stall_count), (i + 1 > 7) ? 7 : i + 1);
    end
    drive3(0, 0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard-detection and forwarding unit for the in-order RISC-V pipeline.
- Tracks in-flight destination registers across a configurable number of post-decode stages.
- Drives per-operand forwarding selects and the load-use stall. Handles a branch/jump flush input.
- Keeps saturating stall and forward event counters for performance debug.
- Sits beside the decoder. Its outputs steer the ID/EX operand muxes and gate the IF/ID hold.

Parameters:
- REG_AW, 5, register address width.
- FWD_STAGES, 2, number of post-ID stages that can forward: stage 1 = EX, stage 2 = MEM, and so on. Range 1..6.
- LOAD_LAT, 1, number of stages a load stays in flight before its data is forwardable. A load in stage k is forwardable only when k > LOAD_LAT. Range 0..FWD_STAGES-1.
- CNT_W, 32, width of the performance counters.

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- id_valid, in, 1, ID holds a real instruction.
- id_rs1, in, REG_AW, source register 1 address.
- id_rs2, in, REG_AW, source register 2 address.
- id_rs1_used, in, 1, instruction reads rs1.
- id_rs2_used, in, 1, instruction reads rs2.
- id_rd, in, REG_AW, destination register address.
- id_regwrite, in, 1, instruction writes rd.
- id_memread, in, 1, instruction is a load.
- flush, in, 1, kill the instruction currently in ID (taken branch or mispredict).
- stall, out, 1, hold IF/ID and insert a bubble into EX.
- fwd_sel1, out, SW = $clog2(FWD_STAGES+1), rs1 source: 0 = register file, k = stage k result.
- fwd_sel2, out, SW, rs2 source, same encoding as fwd_sel1.
- stall_count, out, CNT_W, saturating count of stall cycles.
- fwd_count, out, CNT_W, saturating count of cycles with any nonzero fwd_sel.

Behaviour:
- State is a shift array sb[1..FWD_STAGES]. Each entry holds {v, rd, wr, ld}. Only the state and the counters are registered.
- On rst low (asynchronous): all sb.v = 0, both counters = 0. The outputs then read stall = 0 and fwd_sel1 = fwd_sel2 = 0.
- Each rising edge: sb[k+1] <= sb[k] for k = 1..FWD_STAGES-1. The oldest entry is dropped.
- sb[1] <= {id_valid & ~stall & ~flush, id_rd, id_regwrite, id_memread}. During a stall or a flush, sb[1] receives a bubble (v = 0).
- Match rule: entry k matches operand rs when v & wr & (rd == rs) & (rs != 0) & rs_used & id_valid.
- Per operand, take the smallest matching k (youngest producer wins). If there is no match, fwd_sel = 0.
- Load-use hazard: the youngest match is a load with k <= LOAD_LAT. For that operand fwd_sel = 0, and the hazard contributes to stall.
- Otherwise fwd_sel = k.
- stall = (hazard on rs1 or rs2) & ~flush. Flush overrides stall.
- stall, fwd_sel1 and fwd_sel2 are combinational from the current sb and ID inputs. There is zero-cycle latency to the ID/EX mux.
- A stalled load-use resolves after exactly LOAD_LAT - k + 1 cycles. With the defaults this is 1 cycle.
- stall_count increments on every cycle with stall = 1. fwd_count increments on every cycle with fwd_sel1 != 0 or fwd_sel2 != 0. Both counters hold at 2^CNT_W - 1.
- x0 never matches, even if an entry has rd = 0 with wr = 1.
- Reset asserted mid-stall: stall is deasserted immediately via sb clear. No partial entries survive.
- LOAD_LAT = 0: loads never stall and forward from stage 1.

Test Plan:
- add x5 then add x6,x5,x1 in the next cycle -> fwd_sel1 = 1, fwd_sel2 = 0, stall = 0, fwd_count = 1.
- add x5; nop; sub x7,x2,x5 -> at sub fwd_sel2 = 2, fwd_sel1 = 0, stall = 0.
- lw x5 then add x6,x5,x5 (defaults) -> stall = 1 for exactly 1 cycle. Next cycle fwd_sel1 = fwd_sel2 = 2, stall = 0. stall_count = 1.
- addi x0,x0,1 then add x1,x0,x0 -> fwd_sel1 = fwd_sel2 = 0. Also check rs1_used = 0 with a matching rd gives fwd_sel1 = 0.
- add x7 (older) and or x7 (younger) in flight, then read x7 -> fwd_sel1 = 1, younger wins.
- lw x5; add x6,x5,x0 with flush = 1 on the hazard cycle -> stall = 0, bubble enters sb[1].
- Separately, assert rst low during a stall -> stall = 0 and counters = 0 immediately.
- Force CNT_W = 3 with 9 stall cycles -> stall_count = 7, saturated.
